id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core: it registers decoded operands and control from ID and resolves forwarding from MEM and WB. It then presents final operands `alu_a`, `alu_b`, `shamt` and `alu_ctrl` directly to the ALU in EX. It also detects load-use hazards, stalling IF/ID and inserting a bubble, and applies branch flushes.

## Interface
Parameters:
- `DATA_W`, default 32: datapath width.
- `RA_W`, default 5: register address width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: branch taken; kill the instruction entering EX.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs_data`, `id_rt_data` in DATA_W: register-file read data.
- `id_imm` in DATA_W: sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd` in RA_W: register specifiers.
- `id_shamt` in 5: shift amount.
- `id_alu_ctrl` in 4: ALU op (ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, SLL 0011, SRL 0100).
- `id_alu_src` in 1: 1 selects immediate for B.
- `id_reg_dst` in 1: 1 selects rd, 0 selects rt as destination.
- `id_uses_rt` in 1: instruction reads rt.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1: control.
- `mem_reg_write` in 1, `mem_rd` in RA_W, `mem_result` in DATA_W: MEM-stage writeback source.
- `wb_reg_write` in 1, `wb_rd` in RA_W, `wb_result` in DATA_W: WB-stage writeback source.
- `stall` out 1: hold PC and IF/ID this cycle.
- `alu_a`, `alu_b` out DATA_W: forwarded ALU operands.
- `shamt` out 5, `alu_ctrl` out 4: registered.
- `ex_store_data` out DATA_W: forwarded rt for stores.
- `ex_write_reg` out RA_W: destination, rd or rt.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` out 1: registered control.

## Operation
- **Hazard.** `hz = ex_mem_read & (ex_rt_q != 0) & ((ex_rt_q == id_rs) | (id_uses_rt & ex_rt_q == id_rt)) & id_valid`.
- **Stall.** `stall = hz & ~flush`. It is combinational, in the same cycle as the hazard.
- **Bubble.** `flush | hz` causes, at the clock edge, `ex_valid`, `ex_reg_write`, `ex_mem_read` and `ex_mem_write` to load 0. All other fields load from ID normally.
- **Normal load.** Otherwise every field loads from ID at each edge; the stage has no enable.
- **Forwarding per source operand (rs, then rt), evaluated on registered specifiers:**
  - Use MEM if `mem_reg_write & mem_rd != 0 & mem_rd == spec`.
  - Else use WB if `wb_reg_write & wb_rd != 0 & wb_rd == spec`.
  - Else use the registered register-file data.
  - MEM has priority over WB. Register 0 is never forwarded.
- **ALU operands.**
  - `alu_a` = forwarded rs.
  - `alu_b` = `ex_imm_q` if `alu_src_q`, else forwarded rt.
  - `ex_store_data` = forwarded rt, regardless of `alu_src`.
- **Destination.** `ex_write_reg` = `id_reg_dst ? id_rd : id_rt`, registered.
- **Width.** No arithmetic occurs here. Widths pass through unchanged.

## Timing
- ID to EX latency is 1 cycle. Forwarding muxes are combinational from registered state plus the MEM/WB inputs.
- **Reset.** All registers clear asynchronously, giving: control outputs 0, `alu_ctrl` 0000, `shamt` 0, `ex_write_reg` 0, data registers 0. As a result, `alu_a`/`alu_b` read 0 while MEM/WB do not forward.
- **Reset mid-stall.** `stall` drops immediately, because `ex_mem_read` clears.
- **Flush and hazard together.** Flush wins: bubble inserted, `stall` = 0.
- **Hazard with `id_valid` = 0.** No stall.
- **Back-to-back loads.** At most one stall cycle per dependent instruction. After the bubble, the load sits in MEM and the value comes via the MEM/WB forwarding path.

## Structure
- **Shared package `cpu_pkg`:**
  - ALU control code constants (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`, `ALU_SLL`, `ALU_SRL`).
  - Packed struct `ex_ctrl_t` holding valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_ctrl.
  - Forward-select enum `fwd_sel_t` {`FWD_RF`, `FWD_WB`, `FWD_MEM`}.
- **Sub-module `fwd_mux`:** combinational select for one operand. Instantiate it twice (rs, rt).
- **Top level:** holds the hazard logic and the registers.

## Test plan
- **Reset.** `rst_n` low mid-cycle → all outputs 0 asynchronously, `stall` 0.
- **MEM forward.** ID `add` with rs=3, followed next cycle by `mem_reg_write`=1, `mem_rd`=3, `mem_result`=0x55; WB also targets r3 with 0x11 → `alu_a`=0x55.
- **Register 0 guard.** `mem_rd`=0, `mem_reg_write`=1, spec rs=0, rf data 0 → `alu_a`=0 (no forward).
- **Load-use.** EX holds `lw` to rt=4; ID has rs=4 → `stall`=1 for one cycle. Next cycle `ex_reg_write`=0 and `ex_mem_read`=0; the `add` enters EX one cycle later.
- **Flush with hazard.** Same as load-use plus `flush`=1 → `stall`=0, EX control bubble.
- **Immediate select.** `alu_src`=1, imm=0xFFFF_FFFC, rt forwarded 0x20 → `alu_b`=0xFFFF_FFFC, `ex_store_data`=0x20.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 5-stage MIPS core datapath.
package cpu_pkg;

    // ALU control encodings driven from ID into EX
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Control bundle carried from ID into EX
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_ctrl;
    } ex_ctrl_t;

    // Source chosen for a forwarded operand
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select for one EX source register.
// MEM beats WB; register 0 is hardwired and never forwarded.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic [RA_W-1:0]   spec,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              mem_reg_write,
    input  logic [RA_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] data
);

    fwd_sel_t sel_s;

    // Pick the youngest in-flight producer of the specifier
    always_comb begin
        sel_s = FWD_RF;
        if (mem_reg_write && (mem_rd != {RA_W{1'b0}}) && (mem_rd == spec)) begin
            sel_s = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != {RA_W{1'b0}}) && (wb_rd == spec)) begin
            sel_s = FWD_WB;
        end else begin
            sel_s = FWD_RF;
        end
    end

    // Steer the selected source onto the operand
    always_comb begin
        data = rf_data;
        case (sel_s)
            FWD_MEM: data = mem_result;
            FWD_WB:  data = wb_result;
            FWD_RF:  data = rf_data;
            default: data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush
// and MEM/WB operand forwarding into the EX-stage ALU.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [4:0]        id_shamt,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              mem_reg_write,
    input  logic [RA_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic              stall,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        shamt,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [RA_W-1:0]   ex_write_reg,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    ex_ctrl_t          ex_ctrl_r;
    ex_ctrl_t          ctrl_next_s;
    logic [RA_W-1:0]   ex_rs_r;
    logic [RA_W-1:0]   ex_rt_r;
    logic [RA_W-1:0]   ex_write_reg_r;
    logic [DATA_W-1:0] ex_rs_data_r;
    logic [DATA_W-1:0] ex_rt_data_r;
    logic [DATA_W-1:0] ex_imm_r;
    logic [4:0]        ex_shamt_r;
    logic              hz_s;
    logic              bubble_s;
    logic [DATA_W-1:0] rs_fwd_s;
    logic [DATA_W-1:0] rt_fwd_s;
    logic [DATA_W-1:0] alu_b_s;

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        hz_s = ex_ctrl_r.mem_read
             & (ex_rt_r != {RA_W{1'b0}})
             & ((ex_rt_r == id_rs) | (id_uses_rt & (ex_rt_r == id_rt)))
             & id_valid;
        bubble_s = flush | hz_s;
    end

    // Next EX control; a bubble kills only the side-effecting bits
    always_comb begin
        ctrl_next_s.valid      = id_valid     & ~bubble_s;
        ctrl_next_s.reg_write  = id_reg_write & ~bubble_s;
        ctrl_next_s.mem_read   = id_mem_read  & ~bubble_s;
        ctrl_next_s.mem_write  = id_mem_write & ~bubble_s;
        ctrl_next_s.mem_to_reg = id_mem_to_reg;
        ctrl_next_s.alu_src    = id_alu_src;
        ctrl_next_s.alu_ctrl   = id_alu_ctrl;
    end

    // ID/EX pipeline register; loads every cycle, no enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_r      <= '0;
            ex_rs_r        <= {RA_W{1'b0}};
            ex_rt_r        <= {RA_W{1'b0}};
            ex_write_reg_r <= {RA_W{1'b0}};
            ex_rs_data_r   <= {DATA_W{1'b0}};
            ex_rt_data_r   <= {DATA_W{1'b0}};
            ex_imm_r       <= {DATA_W{1'b0}};
            ex_shamt_r     <= 5'd0;
        end else begin
            ex_ctrl_r      <= ctrl_next_s;
            ex_rs_r        <= id_rs;
            ex_rt_r        <= id_rt;
            ex_write_reg_r <= id_reg_dst ? id_rd : id_rt;
            ex_rs_data_r   <= id_rs_data;
            ex_rt_data_r   <= id_rt_data;
            ex_imm_r       <= id_imm;
            ex_shamt_r     <= id_shamt;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs (
        .spec          (ex_rs_r),
        .rf_data       (ex_rs_data_r),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .data          (rs_fwd_s)
    );

    fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rt (
        .spec          (ex_rt_r),
        .rf_data       (ex_rt_data_r),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .data          (rt_fwd_s)
    );

    // B operand: immediate for I-type, otherwise forwarded rt
    always_comb begin
        if (ex_ctrl_r.alu_src) begin
            alu_b_s = ex_imm_r;
        end else begin
            alu_b_s = rt_fwd_s;
        end
    end

    assign stall         = hz_s & ~flush;
    assign alu_a         = rs_fwd_s;
    assign alu_b         = alu_b_s;
    assign ex_store_data = rt_fwd_s;
    assign shamt         = ex_shamt_r;
    assign alu_ctrl      = ex_ctrl_r.alu_ctrl;
    assign ex_write_reg  = ex_write_reg_r;
    assign ex_valid      = ex_ctrl_r.valid;
    assign ex_reg_write  = ex_ctrl_r.reg_write;
    assign ex_mem_read   = ex_ctrl_r.mem_read;
    assign ex_mem_write  = ex_ctrl_r.mem_write;
    assign ex_mem_to_reg = ex_ctrl_r.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected outputs
// computed by a reference model; a negedge monitor pops and compares.
module tb_id_ex_stage;
    import cpu_pkg::*;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [3:0]  ctrl;
        logic        alu_src;
        logic        reg_dst;
        logic        uses_rt;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        mrw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wrd;
        logic [31:0] wres;
    } stim_t;

    // What the model believes sits in EX
    typedef struct packed {
        logic        valid, rw, mr, mw, m2r, alu_src;
        logic [3:0]  ctrl;
        logic [4:0]  shamt, rs, rt, wreg;
        logic [31:0] rs_data, rt_data, imm;
    } ex_t;

    typedef struct packed {
        logic        stall;
        logic [31:0] alu_a, alu_b, store;
        logic [4:0]  shamt, wreg;
        logic [3:0]  ctrl;
        logic        valid, rw, mr, mw, m2r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush, id_valid, id_alu_src, id_reg_dst, id_uses_rt;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [31:0] id_rs_data, id_rt_data, id_imm, mem_result, wb_result;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt, mem_rd, wb_rd;
    logic [3:0]  id_alu_ctrl;
    logic        mem_reg_write, wb_reg_write;
    logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  shamt, ex_write_reg;
    logic [3:0]  alu_ctrl;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t  sb[$];
    ex_t   ex;
    stim_t cur;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .stall(stall), .alu_a(alu_a), .alu_b(alu_b), .shamt(shamt), .alu_ctrl(alu_ctrl),
        .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg)
    );

    always #5 clk = ~clk;

    // Newest writer wins; r0 is never a forwarding target
    function automatic logic [31:0] fwd(logic [4:0] spec, logic [31:0] rf, stim_t s);
        if (s.mrw && s.mrd != 5'd0 && s.mrd == spec) return s.mres;
        if (s.wrw && s.wrd != 5'd0 && s.wrd == spec) return s.wres;
        return rf;
    endfunction

    // A load in EX blocks any ID reader of its destination
    function automatic logic load_use(ex_t e, stim_t s);
        return e.mr && e.rt != 5'd0 && s.valid &&
               (e.rt == s.rs || (s.uses_rt && e.rt == s.rt));
    endfunction

    function automatic stim_t idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = '0;
        s.rst     = ($urandom_range(0, 39) == 0);
        s.flush   = ($urandom_range(0, 7) == 0);
        s.valid   = ($urandom_range(0, 5) != 0);
        s.rs_data = $urandom;
        s.rt_data = $urandom;
        s.imm     = $urandom;
        s.rs      = 5'($urandom_range(0, 4));
        s.rt      = 5'($urandom_range(0, 4));
        s.rd      = 5'($urandom_range(0, 31));
        s.shamt   = 5'($urandom_range(0, 31));
        s.ctrl    = 4'($urandom_range(0, 15));
        s.alu_src = 1'($urandom);
        s.reg_dst = 1'($urandom);
        s.uses_rt = 1'($urandom);
        s.rw      = 1'($urandom);
        s.mr      = 1'($urandom);
        s.mw      = 1'($urandom);
        s.m2r     = 1'($urandom);
        s.mrw     = 1'($urandom);
        s.mrd     = 5'($urandom_range(0, 4));
        s.mres    = $urandom;
        s.wrw     = 1'($urandom);
        s.wrd     = 5'($urandom_range(0, 4));
        s.wres    = $urandom;
        return s;
    endfunction

    // Advance one cycle: commit the edge into the model, drive new inputs, push expectation
    task automatic step(input stim_t s);
        exp_t  e;
        logic  killed;
        @(posedge clk);
        #1;
        if (cur.rst) begin
            ex = '0;
        end else begin
            killed     = cur.flush || load_use(ex, cur);
            ex.valid   = cur.valid && !killed;
            ex.rw      = cur.rw && !killed;
            ex.mr      = cur.mr && !killed;
            ex.mw      = cur.mw && !killed;
            ex.m2r     = cur.m2r;
            ex.alu_src = cur.alu_src;
            ex.ctrl    = cur.ctrl;
            ex.shamt   = cur.shamt;
            ex.rs      = cur.rs;
            ex.rt      = cur.rt;
            ex.wreg    = cur.reg_dst ? cur.rd : cur.rt;
            ex.rs_data = cur.rs_data;
            ex.rt_data = cur.rt_data;
            ex.imm     = cur.imm;
        end
        cur = s;
        rst_n = !s.rst;         flush = s.flush;          id_valid = s.valid;
        id_rs_data = s.rs_data; id_rt_data = s.rt_data;   id_imm = s.imm;
        id_rs = s.rs;           id_rt = s.rt;             id_rd = s.rd;
        id_shamt = s.shamt;     id_alu_ctrl = s.ctrl;     id_alu_src = s.alu_src;
        id_reg_dst = s.reg_dst; id_uses_rt = s.uses_rt;   id_reg_write = s.rw;
        id_mem_read = s.mr;     id_mem_write = s.mw;      id_mem_to_reg = s.m2r;
        mem_reg_write = s.mrw;  mem_rd = s.mrd;           mem_result = s.mres;
        wb_reg_write = s.wrw;   wb_rd = s.wrd;            wb_result = s.wres;
        if (s.rst) ex = '0;
        e.stall = load_use(ex, s) && !s.flush;
        e.alu_a = fwd(ex.rs, ex.rs_data, s);
        e.store = fwd(ex.rt, ex.rt_data, s);
        e.alu_b = ex.alu_src ? ex.imm : e.store;
        e.shamt = ex.shamt;
        e.wreg  = ex.wreg;
        e.ctrl  = ex.ctrl;
        e.valid = ex.valid;
        e.rw    = ex.rw;
        e.mr    = ex.mr;
        e.mw    = ex.mw;
        e.m2r   = ex.m2r;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare the presented outputs against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("stall",      {31'd0, stall},         {31'd0, e.stall});
            check("alu_a",      alu_a,                  e.alu_a);
            check("alu_b",      alu_b,                  e.alu_b);
            check("store_data", ex_store_data,          e.store);
            check("shamt",      {27'd0, shamt},         {27'd0, e.shamt});
            check("write_reg",  {27'd0, ex_write_reg},  {27'd0, e.wreg});
            check("alu_ctrl",   {28'd0, alu_ctrl},      {28'd0, e.ctrl});
            check("ex_ctrl",    {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                                {27'd0, e.valid, e.rw, e.mr, e.mw, e.m2r});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s, lw, add;
        ex  = '0;
        cur = idle();
        cur.rst = 1'b1;
        rst_n = 1'b0;
        s = idle(); s.rst = 1'b1;
        step(s);
        step(idle());

        // MEM forward beats WB for rs=3
        s = idle(); s.valid = 1'b1; s.rs = 5'd3; s.rt = 5'd5; s.rs_data = 32'h1234;
        s.ctrl = ALU_ADD; s.rw = 1'b1; s.reg_dst = 1'b1; s.rd = 5'd9;
        step(s);
        s = idle(); s.mrw = 1'b1; s.mrd = 5'd3; s.mres = 32'h55;
        s.wrw = 1'b1; s.wrd = 5'd3; s.wres = 32'h11;
        step(s);

        // r0 is never forwarded
        s = idle(); s.valid = 1'b1; s.rs = 5'd0; s.ctrl = ALU_OR;
        step(s);
        s = idle(); s.mrw = 1'b1; s.mrd = 5'd0; s.mres = 32'hDEAD_BEEF;
        step(s);

        // Load-use: lw r4 then add reading r4, held in ID while stalled
        lw = idle(); lw.valid = 1'b1; lw.rt = 5'd4; lw.mr = 1'b1; lw.rw = 1'b1;
        lw.m2r = 1'b1; lw.alu_src = 1'b1; lw.ctrl = ALU_ADD;
        add = idle(); add.valid = 1'b1; add.rs = 5'd4; add.rt = 5'd5; add.uses_rt = 1'b1;
        add.rw = 1'b1; add.reg_dst = 1'b1; add.rd = 5'd7; add.ctrl = ALU_SUB;
        step(lw); step(add); step(add); step(idle());

        // Same hazard while a branch flushes
        step(lw); add.flush = 1'b1; step(add); add.flush = 1'b0; step(idle());

        // Immediate select with rt forwarded from MEM
        s = idle(); s.valid = 1'b1; s.rt = 5'd6; s.alu_src = 1'b1; s.imm = 32'hFFFF_FFFC;
        s.mw = 1'b1; s.ctrl = ALU_SLT;
        step(s);
        s = idle(); s.mrw = 1'b1; s.mrd = 5'd6; s.mres = 32'h20;
        step(s);
        s = idle(); s.valid = 1'b1; s.ctrl = ALU_SLL; s.shamt = 5'd17;
        step(s);
        s = idle(); s.valid = 1'b1; s.ctrl = ALU_SRL; s.rs = 5'd2;
        step(s);
        s = idle(); s.wrw = 1'b1; s.wrd = 5'd2; s.wres = 32'hCAFE_0001;
        step(s);

        for (int i = 0; i < 600; i++) begin
            step(rand_stim());
        end
        s = idle(); s.rst = 1'b1;
        step(s);
        step(idle());
        repeat (2) @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
